// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around the shared memory port.
// Handshake: a requester holds req and its fields until the one-cycle ready pulse; mem_req holds fields until mem_req & mem_ready.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  ifu_req;
    logic [ADDR_W-1:0]     ifu_addr;
    logic                  ifu_ready;
    logic                  ifu_rvalid;
    logic [DATA_W-1:0]     ifu_rdata;

    logic                  lsu_req;
    logic                  lsu_wen;
    logic [ADDR_W-1:0]     lsu_addr;
    logic [DATA_W-1:0]     lsu_wdata;
    logic [DATA_W/8-1:0]   lsu_wmask;
    logic                  lsu_ready;
    logic                  lsu_rvalid;
    logic [DATA_W-1:0]     lsu_rdata;

    logic                  mem_req;
    logic                  mem_wen;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wmask;
    logic                  mem_ready;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  ifu_req, ifu_addr,
        input  lsu_req, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
        input  mem_ready, mem_rvalid, mem_rdata,
        output ifu_ready, ifu_rvalid, ifu_rdata,
        output lsu_ready, lsu_rvalid, lsu_rdata,
        output mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output ifu_req, ifu_addr,
        output lsu_req, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
        output mem_ready, mem_rvalid, mem_rdata,
        input  ifu_ready, ifu_rvalid, ifu_rdata,
        input  lsu_ready, lsu_rvalid, lsu_rdata,
        input  mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store, one transaction in flight.
// LSU has priority; a streak counter hands the port to a waiting IFU after MAX_LSU_STREAK LSU grants.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_LSU_STREAK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus,
    output logic                 busy,
    output logic [1:0]           dbg_state
);
    localparam int MW = DATA_W / 8;
    localparam int SW = $clog2(MAX_LSU_STREAK + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t              state;
    logic                owner_lsu;
    logic [SW-1:0]       streak;
    logic                mem_req_q;
    logic                mem_wen_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [MW-1:0]       mem_wmask_q;
    logic                ifu_rvalid_q;
    logic                lsu_rvalid_q;
    logic [DATA_W-1:0]   ifu_rdata_q;
    logic [DATA_W-1:0]   lsu_rdata_q;

    logic streak_full;
    logic lsu_win;
    logic ifu_win;

    always_comb begin
        streak_full = (streak == SW'(MAX_LSU_STREAK));
        lsu_win     = bus.lsu_req && !(bus.ifu_req && streak_full);
        ifu_win     = bus.ifu_req && !lsu_win;
    end

    // Ready is the only combinational output; gated by rst so reset forces it low at once.
    assign bus.ifu_ready  = rst && (state == IDLE) && ifu_win;
    assign bus.lsu_ready  = rst && (state == IDLE) && lsu_win;
    assign bus.ifu_rvalid = ifu_rvalid_q;
    assign bus.lsu_rvalid = lsu_rvalid_q;
    assign bus.ifu_rdata  = ifu_rdata_q;
    assign bus.lsu_rdata  = lsu_rdata_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_wen    = mem_wen_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_wmask  = mem_wmask_q;
    assign busy           = (state != IDLE);
    assign dbg_state      = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            owner_lsu    <= 1'b0;
            streak       <= '0;
            mem_req_q    <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wmask_q  <= '0;
            ifu_rvalid_q <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            ifu_rdata_q  <= '0;
            lsu_rdata_q  <= '0;
        end else begin
            ifu_rvalid_q <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (lsu_win) begin
                        owner_lsu   <= 1'b1;
                        mem_req_q   <= 1'b1;
                        mem_wen_q   <= bus.lsu_wen;
                        mem_addr_q  <= bus.lsu_addr;
                        mem_wdata_q <= bus.lsu_wdata;
                        mem_wmask_q <= bus.lsu_wen ? bus.lsu_wmask : '0;
                        state       <= REQ;
                        if (!bus.ifu_req)
                            streak <= '0;
                        else if (!streak_full)
                            streak <= streak + SW'(1);
                    end else if (ifu_win) begin
                        owner_lsu   <= 1'b0;
                        mem_req_q   <= 1'b1;
                        mem_wen_q   <= 1'b0;
                        mem_addr_q  <= bus.ifu_addr;
                        mem_wdata_q <= '0;
                        mem_wmask_q <= '0;
                        state       <= REQ;
                        streak      <= '0;
                    end
                end
                REQ: begin
                    if (bus.mem_ready) begin
                        mem_req_q <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        if (owner_lsu) begin
                            lsu_rdata_q  <= bus.mem_rdata;
                            lsu_rvalid_q <= 1'b1;
                        end else begin
                            ifu_rdata_q  <= bus.mem_rdata;
                            ifu_rvalid_q <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic, all checked
// against a transaction-level reference model of the arbitration and routing rules.
module tb_mem_port_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MW   = DW / 8;
    localparam int MAXS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [1:0] dbg_state;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LSU_STREAK(MAXS)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: where the single transaction is in its life, plus its expected contents.
    int            stage;
    bit            t_lsu;
    logic          t_wen;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata;
    logic [MW-1:0] t_wmask;
    logic [DW-1:0] t_rdata;
    int            streak;
    logic [DW-1:0] exp_ifu_rdata;
    logic [DW-1:0] exp_lsu_rdata;
    logic [AW-1:0] exp_q[$];
    bit            grant_log[$];
    int            n_ifu_rv, n_lsu_rv, n_memreq;

    logic          s_ifu_ready, s_lsu_ready, s_ifu_rvalid, s_lsu_rvalid;
    logic          s_mem_req, s_mem_wen, s_busy;
    logic [AW-1:0] s_mem_addr;
    logic [DW-1:0] s_mem_wdata, s_ifu_rdata, s_lsu_rdata;
    logic [MW-1:0] s_mem_wmask;

    function automatic void model_reset();
        stage         = 0;
        streak        = 0;
        exp_ifu_rdata = '0;
        exp_lsu_rdata = '0;
        exp_q.delete();
    endfunction

    task automatic tick();
        int nxt;
        bit e_ir;
        bit e_lr;
        e_ir = 1'b0;
        e_lr = 1'b0;
        @(negedge clk);
        s_ifu_ready  = bus.ifu_ready;   s_lsu_ready  = bus.lsu_ready;
        s_ifu_rvalid = bus.ifu_rvalid;  s_lsu_rvalid = bus.lsu_rvalid;
        s_mem_req    = bus.mem_req;     s_mem_wen    = bus.mem_wen;
        s_mem_addr   = bus.mem_addr;    s_mem_wdata  = bus.mem_wdata;
        s_mem_wmask  = bus.mem_wmask;   s_busy       = busy;
        s_ifu_rdata  = bus.ifu_rdata;   s_lsu_rdata  = bus.lsu_rdata;
        if (s_mem_req)    n_memreq++;
        if (s_ifu_rvalid) n_ifu_rv++;
        if (s_lsu_rvalid) n_lsu_rv++;
        if (!rst) begin
            chk("rst_busy", s_busy, 0);
            chk("rst_state", dbg_state, 0);
            chk("rst_mem_req", s_mem_req, 0);
            chk("rst_ready", {s_ifu_ready, s_lsu_ready}, 0);
            chk("rst_rvalid", {s_ifu_rvalid, s_lsu_rvalid}, 0);
            chk("rst_rdata", {s_ifu_rdata, s_lsu_rdata}, 0);
            model_reset();
        end else begin
            nxt = stage;
            if (stage == 0 && (bus.ifu_req || bus.lsu_req)) begin
                e_lr  = bus.lsu_req && !(bus.ifu_req && streak == MAXS);
                e_ir  = !e_lr;
                t_lsu = e_lr;
                if (e_lr) begin
                    t_wen   = bus.lsu_wen;
                    t_addr  = bus.lsu_addr;
                    t_wdata = bus.lsu_wdata;
                    t_wmask = bus.lsu_wen ? bus.lsu_wmask : '0;
                    streak  = bus.ifu_req ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
                end else begin
                    t_wen   = 1'b0;
                    t_addr  = bus.ifu_addr;
                    t_wdata = '0;
                    t_wmask = '0;
                    streak  = 0;
                end
                grant_log.push_back(e_lr);
                exp_q.push_back(t_addr);
                nxt = 1;
            end
            if (stage == 3) begin
                if (t_lsu) exp_lsu_rdata = t_rdata;
                else       exp_ifu_rdata = t_rdata;
                nxt = 0;
            end
            chk("ifu_ready", s_ifu_ready, e_ir);
            chk("lsu_ready", s_lsu_ready, e_lr);
            chk("busy", s_busy, stage != 0);
            chk("mem_req", s_mem_req, stage == 1);
            chk("ifu_rvalid", s_ifu_rvalid, stage == 3 && !t_lsu);
            chk("lsu_rvalid", s_lsu_rvalid, stage == 3 && t_lsu);
            chk("ifu_rdata", s_ifu_rdata, exp_ifu_rdata);
            chk("lsu_rdata", s_lsu_rdata, exp_lsu_rdata);
            if (stage == 1) begin
                chk("mem_addr", s_mem_addr, exp_q[0]);
                chk("mem_wen", s_mem_wen, t_wen);
                chk("mem_wmask", s_mem_wmask, t_wmask);
                if (t_wen) chk("mem_wdata", s_mem_wdata, t_wdata);
                if (bus.mem_ready) begin
                    void'(exp_q.pop_front());
                    nxt = 2;
                end
            end
            if (stage == 2 && bus.mem_rvalid) begin
                t_rdata = bus.mem_rdata;
                nxt     = 3;
            end
            stage = nxt;
        end
        @(posedge clk);
        #1;
    endtask

    // Memory that accepts at once and answers the cycle after acceptance.
    task automatic auto_cycles(input int n, input bit drop);
        for (int i = 0; i < n; i++) begin
            bus.mem_ready  = 1'b1;
            bus.mem_rvalid = (stage == 2);
            bus.mem_rdata  = $urandom;
            tick();
            if (drop && s_ifu_ready) bus.ifu_req = 1'b0;
            if (drop && s_lsu_ready) bus.lsu_req = 1'b0;
        end
        bus.mem_rvalid = 1'b0;
    endtask

    initial begin
        logic [9:0] got;
        rst = 1'b0;
        bus.ifu_req = 0; bus.ifu_addr = '0;
        bus.lsu_req = 0; bus.lsu_wen = 0; bus.lsu_addr = '0; bus.lsu_wdata = '0; bus.lsu_wmask = '0;
        bus.mem_ready = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
        model_reset();
        n_ifu_rv = 0; n_lsu_rv = 0; n_memreq = 0;
        tick();
        tick();
        rst = 1'b1;

        // IFU read only
        bus.ifu_req = 1; bus.ifu_addr = 32'h8000_0000; bus.mem_ready = 1;
        tick();
        chk("t1_ifu_ready_c0", s_ifu_ready, 1);
        bus.ifu_req = 0;
        tick();
        chk("t1_mem_req_c1", s_mem_req, 1);
        chk("t1_mem_wen_wmask", {s_mem_wen, s_mem_wmask}, 0);
        bus.mem_ready = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h0010_0073;
        tick();
        bus.mem_rvalid = 0;
        tick();
        chk("t1_ifu_rvalid_c3", s_ifu_rvalid, 1);
        chk("t1_ifu_rdata", s_ifu_rdata, 32'h0010_0073);
        chk("t1_lsu_rvalid", s_lsu_rvalid, 0);
        tick();

        // Simultaneous requests: LSU first, IFU in the next IDLE
        grant_log.delete(); n_ifu_rv = 0; n_lsu_rv = 0;
        bus.ifu_req = 1; bus.ifu_addr = 32'h8000_0100;
        bus.lsu_req = 1; bus.lsu_wen = 0; bus.lsu_addr = 32'h8000_1000;
        bus.lsu_wdata = $urandom; bus.lsu_wmask = 4'hF;
        tick();
        chk("t2_ready_pair", {s_lsu_ready, s_ifu_ready}, 2'b10);
        bus.lsu_req = 0; bus.mem_ready = 1;
        tick();
        chk("t2_first_addr", s_mem_addr, 32'h8000_1000);
        chk("t2_load_wmask", s_mem_wmask, 0);
        auto_cycles(7, 1);
        chk("t2_grants", {grant_log.size() == 2, grant_log[0], grant_log[1]}, 3'b110);
        chk("t2_rv_counts", {n_ifu_rv[7:0], n_lsu_rv[7:0]}, 16'h0101);

        // LSU store
        n_lsu_rv = 0;
        bus.ifu_req = 0;
        bus.lsu_req = 1; bus.lsu_wen = 1; bus.lsu_addr = 32'h8000_2000;
        bus.lsu_wdata = 32'hDEAD_BEEF; bus.lsu_wmask = 4'hF;
        tick();
        chk("t3_lsu_ready", s_lsu_ready, 1);
        bus.lsu_req = 0; bus.mem_ready = 1;
        tick();
        chk("t3_mem_wen", s_mem_wen, 1);
        chk("t3_mem_wdata", s_mem_wdata, 32'hDEAD_BEEF);
        chk("t3_mem_wmask", s_mem_wmask, 4'hF);
        auto_cycles(3, 1);
        chk("t3_write_ack", n_lsu_rv, 1);

        // Starvation limit with both requesters held
        grant_log.delete();
        bus.ifu_req = 1; bus.ifu_addr = 32'h8000_0200;
        bus.lsu_req = 1; bus.lsu_wen = 0; bus.lsu_addr = 32'h8000_1100;
        auto_cycles(40, 0);
        bus.ifu_req = 0; bus.lsu_req = 0;
        for (int k = 0; k < 10; k++) got[9-k] = grant_log[k];
        chk("t4_grant_count", grant_log.size(), 10);
        chk("t4_grant_order", got, 10'b1111011110);
        tick();

        // Memory stall in REQ, LSU waiting meanwhile
        bus.ifu_req = 1; bus.ifu_addr = 32'h8000_3000;
        tick();
        chk("t5_ifu_ready", s_ifu_ready, 1);
        bus.ifu_req = 0;
        bus.lsu_req = 1; bus.lsu_wen = 0; bus.lsu_addr = 32'h8000_5000;
        bus.mem_ready = 0; n_memreq = 0;
        repeat (5) begin
            tick();
            chk("t5_stall_busy", s_busy, 1);
        end
        bus.mem_ready = 1;
        tick();
        chk("t5_mem_req_cycles", n_memreq, 6);
        auto_cycles(8, 1);

        // Reset while waiting for the response
        bus.lsu_req = 1; bus.lsu_wen = 0; bus.lsu_addr = 32'h8000_4000;
        tick();
        bus.lsu_req = 0; bus.mem_ready = 1;
        tick();
        bus.mem_ready = 0;
        bus.lsu_req = 1;
        #2 rst = 1'b0;
        #1;
        chk("t6_async_busy", busy, 0);
        chk("t6_async_mem_req", bus.mem_req, 0);
        chk("t6_async_ready", {bus.ifu_ready, bus.lsu_ready}, 0);
        chk("t6_async_lsu_rdata", bus.lsu_rdata, 0);
        model_reset();
        tick();
        rst = 1'b1;
        bus.lsu_req = 0;
        bus.mem_rvalid = 1; bus.mem_rdata = 32'h1234_5678;
        n_ifu_rv = 0; n_lsu_rv = 0;
        tick();
        bus.mem_rvalid = 0;
        tick();
        chk("t6_stray_rvalid", n_ifu_rv + n_lsu_rv, 0);
        chk("t6_stray_busy", s_busy, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if (s_ifu_ready || !bus.ifu_req) begin
                bus.ifu_req  = ($urandom_range(0, 2) == 0);
                bus.ifu_addr = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                bus.ifu_req = 0;
            end
            if (s_lsu_ready || !bus.lsu_req) begin
                bus.lsu_req   = ($urandom_range(0, 1) == 0);
                bus.lsu_wen   = $urandom_range(0, 1);
                bus.lsu_addr  = $urandom;
                bus.lsu_wdata = $urandom;
                bus.lsu_wmask = MW'($urandom);
            end
            bus.mem_ready  = ($urandom_range(0, 2) != 0);
            bus.mem_rvalid = (stage == 2) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
            bus.mem_rdata  = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
